// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: one radix-2 step per cycle on operand
// magnitudes, with a fixed ARCH_LEN+1 cycle latency from accept to the result strobe.
module muldiv_sequencer #(
  parameter int unsigned ARCH_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          func3,
  input  logic [ARCH_LEN-1:0] operand1,
  input  logic [ARCH_LEN-1:0] operand2,
  input  logic                flush,
  output logic                stall_o,
  output logic                busy,
  output logic                resp_valid,
  output logic [ARCH_LEN-1:0] resp_result
);

  localparam int unsigned CW = (ARCH_LEN > 1) ? $clog2(ARCH_LEN) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [2:0]              func_q, func_d;
  logic                    neg1_q, neg1_d;
  logic                    neg2_q, neg2_d;
  logic                    div0_q, div0_d;
  logic [ARCH_LEN-1:0]     a_q, a_d;
  logic [2*ARCH_LEN-1:0]   acc_q, acc_d;
  logic [ARCH_LEN-1:0]     resp_result_q, resp_result_d;

  logic                    accept;
  logic                    last_step;
  logic                    in_neg1, in_neg2;
  logic [ARCH_LEN-1:0]     mag1, mag2;
  logic [ARCH_LEN:0]       mul_sum;
  logic [2*ARCH_LEN-1:0]   mul_step;
  logic [ARCH_LEN:0]       div_shift;
  logic [ARCH_LEN:0]       div_diff;
  logic [2*ARCH_LEN-1:0]   div_step;
  logic [2*ARCH_LEN-1:0]   step;
  logic [2*ARCH_LEN-1:0]   prod;
  logic [ARCH_LEN-1:0]     mul_res, quo_res, rem_res, fin_res;

  function automatic logic [ARCH_LEN-1:0] abs_val(input logic [ARCH_LEN-1:0] v,
                                                  input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign accept    = (state_q == StIdle) & req_valid & ~flush;
  assign last_step = (cnt_q == CW'(ARCH_LEN - 1));

  // Operand signedness: MULH/MULHSU/DIV/REM treat rs1 as signed; MULH/DIV/REM treat rs2 so.
  assign in_neg1 = operand1[ARCH_LEN-1] &
                   ((func3 == 3'b001) | (func3 == 3'b010) | (func3[2] & ~func3[0]));
  assign in_neg2 = operand2[ARCH_LEN-1] & ((func3 == 3'b001) | (func3[2] & ~func3[0]));
  assign mag1    = abs_val(operand1, in_neg1);
  assign mag2    = abs_val(operand2, in_neg2);

  // acc holds {partial_hi, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*ARCH_LEN-1:ARCH_LEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_step  = {mul_sum, acc_q[ARCH_LEN-1:1]};
    div_shift = {acc_q[2*ARCH_LEN-1:ARCH_LEN], acc_q[ARCH_LEN-1]};
    div_diff  = div_shift - {1'b0, a_q};
    if (div_diff[ARCH_LEN]) begin
      div_step = {div_shift[ARCH_LEN-1:0], acc_q[ARCH_LEN-2:0], 1'b0};
    end else begin
      div_step = {div_diff[ARCH_LEN-1:0], acc_q[ARCH_LEN-2:0], 1'b1};
    end
    step = func_q[2] ? div_step : mul_step;
  end

  // Sign fix-up of the final step; a zero divisor leaves |rs1| as remainder, so only the
  // quotient needs overriding.
  always_comb begin
    prod    = (neg1_q ^ neg2_q) ? (~step + 1'b1) : step;
    mul_res = (func_q[1:0] == 2'b00) ? prod[ARCH_LEN-1:0] : prod[2*ARCH_LEN-1:ARCH_LEN];
    quo_res = div0_q ? '1 : abs_val(step[ARCH_LEN-1:0], neg1_q ^ neg2_q);
    rem_res = abs_val(step[2*ARCH_LEN-1:ARCH_LEN], neg1_q);
    fin_res = func_q[2] ? (func_q[1] ? rem_res : quo_res) : mul_res;
  end

  always_comb begin
    cnt_d         = cnt_q;
    func_d        = func_q;
    neg1_d        = neg1_q;
    neg2_d        = neg2_q;
    div0_d        = div0_q;
    a_d           = a_q;
    acc_d         = acc_q;
    resp_result_d = resp_result_q;
    if (accept) begin
      cnt_d  = '0;
      func_d = func3;
      neg1_d = in_neg1;
      neg2_d = in_neg2;
      div0_d = (operand2 == '0);
      if (func3[2]) begin
        a_d   = mag2;
        acc_d = {{ARCH_LEN{1'b0}}, mag1};
      end else begin
        a_d   = mag1;
        acc_d = {{ARCH_LEN{1'b0}}, mag2};
      end
    end else if ((state_q == StRun) && !flush) begin
      cnt_d = cnt_q + 1'b1;
      acc_d = step;
      if (last_step) begin
        resp_result_d = fin_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      func_q        <= '0;
      neg1_q        <= 1'b0;
      neg2_q        <= 1'b0;
      div0_q        <= 1'b0;
      a_q           <= '0;
      acc_q         <= '0;
      resp_result_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      func_q        <= func_d;
      neg1_q        <= neg1_d;
      neg2_q        <= neg2_d;
      div0_q        <= div0_d;
      a_q           <= a_d;
      acc_q         <= acc_d;
      resp_result_q <= resp_result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (req_valid) state_d = StRun;
        StRun:   if (last_step) state_d = StDone;
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    req_ready   = (state_q == StIdle);
    busy        = (state_q != StIdle);
    stall_o     = (state_q == StRun) | ((state_q == StIdle) & req_valid & ~flush);
    resp_valid  = (state_q == StDone) & ~flush;
    resp_result = resp_result_q;
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter ARCH_LEN, default 32, the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, execute stage presents an M-extension op.
REQ-005 SHALL have port req_ready, output, 1, sequencer can accept an op this cycle.
REQ-006 SHALL have port func3, input, 3, op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port operand1, input, ARCH_LEN, rs1 value (multiplicand/dividend).
REQ-008 SHALL have port operand2, input, ARCH_LEN, rs2 value (multiplier/divisor).
REQ-009 SHALL have port flush, input, 1, abort any op in flight (branch mispredict/trap).
REQ-010 SHALL have port stall_o, output, 1, hold upstream pipeline stages.
REQ-011 SHALL have port busy, output, 1, sequencer not in IDLE.
REQ-012 SHALL have port resp_valid, output, 1, one-cycle result strobe.
REQ-013 SHALL have port resp_result, output, ARCH_LEN, result, valid only while resp_valid=1.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL drive req_ready=1 only in IDLE; accept = req_valid & req_ready & ~flush.
REQ-016 SHALL on accept latch func3, operands, operand signs, and go IDLE->RUN with iteration counter=0.
REQ-017 SHALL in RUN perform one radix-2 step per cycle (shift-add multiply or restoring divide on magnitudes), counter +1 per cycle.
REQ-018 SHALL transition RUN->DONE when counter reaches ARCH_LEN-1 (exactly ARCH_LEN RUN cycles).
REQ-019 SHALL in DONE assert resp_valid=1 with final resp_result, then return to IDLE next cycle; no backpressure on response.
REQ-020 SHALL give fixed latency: resp_valid in cycle accept+ARCH_LEN+1 for every op, including divide-by-zero.
REQ-021 SHALL compute MUL as low ARCH_LEN bits; MULH/MULHSU/MULHU as high ARCH_LEN bits of 2*ARCH_LEN product with signed*signed, signed*unsigned, unsigned*unsigned respectively.
REQ-022 SHALL compute DIV/REM signed with quotient truncated toward zero and remainder sign = dividend sign; DIVU/REMU unsigned.
REQ-023 SHALL for divisor=0 return quotient all ones (DIV and DIVU) and remainder=operand1 (REM and REMU).
REQ-024 SHALL for DIV of most-negative value by -1 return most-negative value and REM 0.
REQ-025 SHALL drive stall_o = (state==RUN) | (state==IDLE & req_valid & ~flush); stall_o=0 in DONE.
REQ-026 SHALL drive busy=1 in RUN and DONE.
REQ-027 SHALL on flush in any state go to IDLE next cycle, emit no resp_valid, discard partial result; flush in DONE suppresses that cycle's resp_valid.
REQ-028 SHALL ignore req_valid outside IDLE; back-to-back ops: next accept no earlier than cycle after DONE.
REQ-029 SHALL hold resp_result at last value when resp_valid=0 (no X propagation).

Reset
REQ-030 SHALL on rst=1 at a clock edge force state IDLE, counter 0, resp_valid 0, resp_result 0, internal accumulators 0, regardless of state, including mid-RUN.
REQ-031 SHALL give rst priority over flush and accept in the same cycle.
REQ-032 SHALL drive req_ready=1, busy=0, stall_o=0 in the first cycle after reset release with req_valid=0.

Verification
REQ-033 SHALL cover MUL 7*(-3) (0x00000007, 0xFFFFFFFD) -> resp_result 0xFFFFFFEB at accept+33; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-034 SHALL cover DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
REQ-035 SHALL cover DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5, all at accept+33.
REQ-036 SHALL cover flush at RUN cycle 10 -> no resp_valid, IDLE next cycle; flush with req_valid in IDLE -> not accepted, stall_o=0.
REQ-037 SHALL cover rst asserted mid-RUN -> IDLE, resp_valid=0, resp_result=0 next cycle; a new op then completes normally.
REQ-038 SHALL cover req_valid held high continuously -> accepts spaced exactly ARCH_LEN+2 cycles apart, stall_o low only in DONE cycles.
